// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
//
// This block sits after the UART byte receiver. It turns the receiver's byte
// strobes into checked command frames with this layout:
//     SYNC, CMD, LEN, LEN payload bytes, CHK
// CHK is the 8-bit XOR of CMD, LEN and every payload byte. SYNC is not part
// of the checksum.
//
// Inside a frame, the gap between two bytes is measured in sample_tick
// pulses. If the gap reaches TIMEOUT_TICKS, the partial frame is discarded.
//
// A finished frame is held on the frame_* outputs with frame_valid high.
// It is released when the downstream side handshakes it.
//
// Handshake (frame_valid / frame_ready):
//   The transfer happens on the rising clk_50MHz edge where frame_valid and
//   frame_ready are both high. While frame_valid is high, frame_cmd,
//   frame_len and frame_payload do not change. frame_valid does not depend
//   combinationally on frame_ready. frame_valid drops in the cycle after the
//   transfer.
//
// Ports:
//   clk_50MHz      in   system clock
//   reset          in   asynchronous, active-high reset
//   sample_tick    in   oversampling tick from the baud generator
//   rx_valid       in   one-cycle strobe: rx_data holds a new byte
//   rx_data[7:0]   in   received byte
//   frame_valid    out  complete, checked frame available (HOLD state)
//   frame_ready    in   downstream accepts the frame
//   frame_cmd[7:0] out  command byte
//   frame_len[3:0] out  payload length
//   frame_payload  out  payload, byte i at [8i+7:8i]
//   err_checksum   out  one-cycle pulse: CHK byte did not match
//   err_length     out  one-cycle pulse: LEN > MAX_LEN
//   err_timeout    out  one-cycle pulse: inter-byte timeout inside a frame
//   err_overrun    out  one-cycle pulse: byte dropped while holding a frame
//   busy           out  high in every state except IDLE
// ---------------------------------------------------------------------------
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE     = 8'hAA,
    parameter int         MAX_LEN       = 8,
    parameter int         TIMEOUT_TICKS = 2048
) (
    input  logic                   clk_50MHz,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [7:0]             frame_cmd,
    output logic [3:0]             frame_len,
    output logic [MAX_LEN*8-1:0]   frame_payload,
    output logic                   err_checksum,
    output logic                   err_length,
    output logic                   err_timeout,
    output logic                   err_overrun,
    output logic                   busy
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

    // The timeout fires on the tick that would bring the counter to
    // TIMEOUT_TICKS. The counter is cleared at that point, so it never
    // actually holds that value.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [7:0]             r_cmd;
    logic [3:0]             r_len;
    logic [MAX_LEN*8-1:0]   r_payload;
    logic [7:0]             r_acc;
    logic [3:0]             r_idx;
    logic [CNT_W-1:0]       r_tmo_cnt;

    logic                   r_err_checksum;
    logic                   r_err_length;
    logic                   r_err_timeout;
    logic                   r_err_overrun;

    logic                   w_active;
    logic                   w_timeout;
    logic                   w_len_bad;
    logic                   w_len_zero;
    logic                   w_last_byte;
    logic                   w_ev_checksum;
    logic                   w_ev_length;
    logic                   w_ev_overrun;

    // ------------------------------------------------------------------
    // Shared decode used by the next-state logic and the datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_active    = (r_state == S_CMD) || (r_state == S_LEN) ||
                      (r_state == S_PAYLOAD) || (r_state == S_CHECK);

        // A byte arriving in the same cycle as a tick takes priority, so a
        // timeout can only happen in a cycle with no rx_valid.
        w_timeout   = w_active && !rx_valid && sample_tick &&
                      (r_tmo_cnt >= TMO_LAST);

        w_len_bad   = (rx_data > 8'(MAX_LEN));
        w_len_zero  = (rx_data == 8'h00);
        w_last_byte = (r_idx == (r_len - 4'd1));
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic and error events
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_ev_checksum = 1'b0;
        w_ev_length   = 1'b0;
        w_ev_overrun  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Bytes other than SYNC are line noise and are ignored.
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_state_next = S_CMD;
                end
            end

            S_CMD: begin
                if (rx_valid) begin
                    w_state_next = S_LEN;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end

            S_LEN: begin
                if (rx_valid) begin
                    if (w_len_bad) begin
                        w_ev_length  = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (w_len_zero) begin
                        w_state_next = S_CHECK;
                    end else begin
                        w_state_next = S_PAYLOAD;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end

            S_PAYLOAD: begin
                if (rx_valid) begin
                    if (w_last_byte) begin
                        w_state_next = S_CHECK;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end

            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == r_acc) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_ev_checksum = 1'b1;
                        w_state_next  = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end

            S_HOLD: begin
                // The held frame has priority. Any byte arriving now is
                // lost, even a SYNC, and even if the frame leaves in this
                // same cycle.
                if (rx_valid) begin
                    w_ev_overrun = 1'b1;
                end
                if (frame_ready) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // Both are decoded from the state flop only, so there is no
    // combinational path from inputs to outputs.
    // ------------------------------------------------------------------
    always_comb begin
        frame_valid = (r_state == S_HOLD);
        busy        = (r_state != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath: frame fields, checksum, index, timeout counter, error pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_cmd          <= 8'h00;
            r_len          <= 4'h0;
            r_payload      <= '0;
            r_acc          <= 8'h00;
            r_idx          <= 4'h0;
            r_tmo_cnt      <= '0;
            r_err_checksum <= 1'b0;
            r_err_length   <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overrun  <= 1'b0;
        end else begin
            // Each error flag is high for one cycle per event. The events
            // are mutually exclusive by construction.
            r_err_checksum <= w_ev_checksum;
            r_err_length   <= w_ev_length;
            r_err_timeout  <= w_timeout;
            r_err_overrun  <= w_ev_overrun;

            // The counter only runs inside a frame. It is cleared by every
            // received byte and after it expires.
            if (!w_active || rx_valid || w_timeout) begin
                r_tmo_cnt <= '0;
            end else if (sample_tick) begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end

            case (r_state)
                S_CMD: begin
                    if (rx_valid) begin
                        r_cmd     <= rx_data;
                        r_acc     <= rx_data;
                        r_payload <= '0;
                    end
                end

                S_LEN: begin
                    if (rx_valid) begin
                        r_acc <= r_acc ^ rx_data;
                        if (!w_len_bad) begin
                            r_len <= rx_data[3:0];
                            r_idx <= 4'h0;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (rx_valid) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (r_idx == 4'(i)) begin
                                r_payload[i*8 +: 8] <= rx_data;
                            end
                        end
                        r_acc <= r_acc ^ rx_data;
                        r_idx <= r_idx + 4'd1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign frame_cmd     = r_cmd;
    assign frame_len     = r_len;
    assign frame_payload = r_payload;
    assign err_checksum  = r_err_checksum;
    assign err_length    = r_err_length;
    assign err_timeout   = r_err_timeout;
    assign err_overrun   = r_err_overrun;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam int MAX_LEN = 8;

  logic                 clk_50MHz = 1'b0;
  logic                 reset;
  logic                 sample_tick;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [7:0]           frame_cmd;
  logic [3:0]           frame_len;
  logic [MAX_LEN*8-1:0] frame_payload;
  logic                 err_checksum;
  logic                 err_length;
  logic                 err_timeout;
  logic                 err_overrun;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  // Running counts of error pulses and handshakes, sampled on the inactive edge
  int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0, n_xfer = 0;
  int b_chk, b_len, b_tmo, b_ovr, b_xfer;

  uart_frame_parser #(
    .SYNC_BYTE(8'hAA),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_TICKS(2048)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .reset(reset),
    .sample_tick(sample_tick),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_cmd(frame_cmd),
    .frame_len(frame_len),
    .frame_payload(frame_payload),
    .err_checksum(err_checksum),
    .err_length(err_length),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .busy(busy)
  );

  // ---------------- clock ----------------
  always #10 clk_50MHz = ~clk_50MHz;

  always @(negedge clk_50MHz) begin
    if (err_checksum) n_chk++;
    if (err_length) n_len++;
    if (err_timeout) n_tmo++;
    if (err_overrun) n_ovr++;
    if (frame_valid && frame_ready) n_xfer++;
  end

  // ---------------- driver tasks ----------------
  // Every task starts and ends 2 ns after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_50MHz);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    cyc(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic ticks(input int n);
    sample_tick = 1'b1;
    cyc(n);
    sample_tick = 1'b0;
  endtask

  task automatic snap();
    b_chk = n_chk; b_len = n_len; b_tmo = n_tmo; b_ovr = n_ovr; b_xfer = n_xfer;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; sample_tick = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; frame_ready = 1'b0;
    #5;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", frame_valid); end
    cyc(2);
    reset = 1'b0;
    cyc(1);
    checks++; if (frame_cmd !== 8'h00) begin errors++; $display("FAIL rst_cmd got %h exp 00", frame_cmd); end
    checks++; if (frame_len !== 4'h0) begin errors++; $display("FAIL rst_len got %h exp 0", frame_len); end
    checks++; if (frame_payload !== 64'h0) begin errors++; $display("FAIL rst_payload got %h exp 0", frame_payload); end
    checks++; if ({err_checksum, err_length, err_timeout, err_overrun} !== 4'b0000)
      begin errors++; $display("FAIL rst_errs got %b exp 0000", {err_checksum, err_length, err_timeout, err_overrun}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy2 got %b exp 0", busy); end
  endtask

  task automatic test_good_frame();
    frame_ready = 1'b1;
    snap();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h5A); send_byte(8'hA5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy got %b exp 1", busy); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_early_valid got %b exp 0", frame_valid); end
    send_byte(8'hED);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b exp 1", frame_valid); end
    checks++; if (frame_cmd !== 8'h10) begin errors++; $display("FAIL good_cmd got %h exp 10", frame_cmd); end
    checks++; if (frame_len !== 4'h2) begin errors++; $display("FAIL good_len got %h exp 2", frame_len); end
    checks++; if (frame_payload !== 64'h0000_0000_0000_A55A) begin errors++; $display("FAIL good_payload got %h exp 000000000000a55a", frame_payload); end
    cyc(1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_valid_drop got %b exp 0", frame_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_idle got %b exp 0", busy); end
    cyc(1);
    checks++; if (n_xfer - b_xfer !== 1) begin errors++; $display("FAIL good_xfers got %0d exp 1", n_xfer - b_xfer); end
    checks++; if ((n_chk + n_len + n_tmo + n_ovr) - (b_chk + b_len + b_tmo + b_ovr) !== 0)
      begin errors++; $display("FAIL good_no_err got %0d exp 0", (n_chk + n_len + n_tmo + n_ovr) - (b_chk + b_len + b_tmo + b_ovr)); end
  endtask

  task automatic test_bad_checksum();
    frame_ready = 1'b1;
    snap();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'hEE);
    checks++; if (err_checksum !== 1'b1) begin errors++; $display("FAIL chk_pulse got %b exp 1", err_checksum); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL chk_valid got %b exp 0", frame_valid); end
    cyc(1);
    checks++; if (err_checksum !== 1'b0) begin errors++; $display("FAIL chk_pulse_end got %b exp 0", err_checksum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chk_idle got %b exp 0", busy); end
    send_byte(8'hAA); send_byte(8'h33); send_byte(8'h00); send_byte(8'h33);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL len0_valid got %b exp 1", frame_valid); end
    checks++; if (frame_cmd !== 8'h33) begin errors++; $display("FAIL len0_cmd got %h exp 33", frame_cmd); end
    checks++; if (frame_len !== 4'h0) begin errors++; $display("FAIL len0_len got %h exp 0", frame_len); end
    checks++; if (frame_payload !== 64'h0) begin errors++; $display("FAIL len0_payload got %h exp 0", frame_payload); end
    cyc(2);
    checks++; if (n_chk - b_chk !== 1) begin errors++; $display("FAIL chk_count got %0d exp 1", n_chk - b_chk); end
  endtask

  task automatic test_length_noise();
    snap();
    send_byte(8'h55);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noise55_busy got %b exp 0", busy); end
    send_byte(8'h11);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noise11_busy got %b exp 0", busy); end
    send_byte(8'hAA);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sync_busy got %b exp 1", busy); end
    send_byte(8'h01); send_byte(8'h09);
    checks++; if (err_length !== 1'b1) begin errors++; $display("FAIL len_pulse got %b exp 1", err_length); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len_idle got %b exp 0", busy); end
    cyc(2);
    checks++; if (n_len - b_len !== 1) begin errors++; $display("FAIL len_count got %0d exp 1", n_len - b_len); end
  endtask

  task automatic test_timeout();
    frame_ready = 1'b1;
    snap();
    send_byte(8'hAA); send_byte(8'h10);
    ticks(2047);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_early_busy got %b exp 1", busy); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp 0", err_timeout); end
    ticks(1);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse got %b exp 1", err_timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got %b exp 0", busy); end
    cyc(2);
    checks++; if (n_tmo - b_tmo !== 1) begin errors++; $display("FAIL tmo_count got %0d exp 1", n_tmo - b_tmo); end

    // Gaps of 2047 ticks between every byte must never expire.
    snap();
    send_byte(8'hAA); send_byte(8'h10);
    ticks(2047);
    send_byte(8'h01);
    ticks(2047);
    send_byte(8'h77);
    ticks(2047);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_restart_busy got %b exp 1", busy); end
    send_byte(8'h66);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL tmo_frame_valid got %b exp 1", frame_valid); end
    checks++; if (frame_payload !== 64'h77) begin errors++; $display("FAIL tmo_payload got %h exp 77", frame_payload); end
    checks++; if (frame_len !== 4'h1) begin errors++; $display("FAIL tmo_len got %h exp 1", frame_len); end
    cyc(2);
    checks++; if (n_tmo - b_tmo !== 0) begin errors++; $display("FAIL tmo_none got %0d exp 0", n_tmo - b_tmo); end
  endtask

  task automatic test_backpressure();
    frame_ready = 1'b0;
    snap();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'hED);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", frame_valid); end
    cyc(50);
    send_byte(8'hAA);
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL bp_ovr_pulse got %b exp 1", err_overrun); end
    cyc(49);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp_held got %b exp 1", frame_valid); end
    checks++; if (frame_cmd !== 8'h10) begin errors++; $display("FAIL bp_cmd got %h exp 10", frame_cmd); end
    checks++; if (frame_len !== 4'h2) begin errors++; $display("FAIL bp_len got %h exp 2", frame_len); end
    checks++; if (frame_payload !== 64'hA55A) begin errors++; $display("FAIL bp_payload got %h exp a55a", frame_payload); end
    checks++; if (n_ovr - b_ovr !== 1) begin errors++; $display("FAIL bp_ovr_count got %0d exp 1", n_ovr - b_ovr); end
    checks++; if (n_xfer - b_xfer !== 0) begin errors++; $display("FAIL bp_no_xfer got %0d exp 0", n_xfer - b_xfer); end
    frame_ready = 1'b1;
    cyc(1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", frame_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", busy); end
    cyc(2);
    checks++; if (n_xfer - b_xfer !== 1) begin errors++; $display("FAIL bp_xfers got %0d exp 1", n_xfer - b_xfer); end
  endtask

  task automatic test_reset_mid_frame();
    frame_ready = 1'b1;
    snap();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h5A);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    checks++; if (frame_payload !== 64'h5A) begin errors++; $display("FAIL mid_payload got %h exp 5a", frame_payload); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", busy); end
    checks++; if (frame_cmd !== 8'h00) begin errors++; $display("FAIL arst_cmd got %h exp 00", frame_cmd); end
    checks++; if (frame_len !== 4'h0) begin errors++; $display("FAIL arst_len got %h exp 0", frame_len); end
    checks++; if (frame_payload !== 64'h0) begin errors++; $display("FAIL arst_payload got %h exp 0", frame_payload); end
    cyc(2);
    reset = 1'b0;
    cyc(1);
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'hED);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL post_valid got %b exp 1", frame_valid); end
    checks++; if (frame_payload !== 64'hA55A) begin errors++; $display("FAIL post_payload got %h exp a55a", frame_payload); end
    cyc(2);
    checks++; if ((n_chk + n_len + n_tmo + n_ovr) - (b_chk + b_len + b_tmo + b_ovr) !== 0)
      begin errors++; $display("FAIL post_no_err got %0d exp 0", (n_chk + n_len + n_tmo + n_ovr) - (b_chk + b_len + b_tmo + b_ovr)); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length_noise();
    test_timeout();
    test_backpressure();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
